// File: rtl/lut_arbiter.sv
// Round-robin arbiter sharing one activation LUT between NUM_REQ requesters.
// One request in flight at a time: grant, hold x for the ROM latency, return tagged y.
module lut_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int LUT_LATENCY = 1,
    parameter int ID_W        = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ*16-1:0]  req_x,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [15:0]            lut_x,
    output logic                   lut_x_valid,
    input  logic [15:0]            lut_y,
    output logic [15:0]            rsp_y,
    output logic [ID_W-1:0]        rsp_id,
    output logic                   rsp_valid,
    input  logic                   rsp_ready
);

    localparam int CNT_W = (LUT_LATENCY < 2) ? 1 : $clog2(LUT_LATENCY + 1);

    typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

    state_e           state_q, state_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      x_q, x_d;
    logic [15:0]      rsp_y_q, rsp_y_d;
    logic             lut_x_valid_q, lut_x_valid_d;
    logic             rsp_valid_q, rsp_valid_d;

    logic             found;
    logic [ID_W-1:0]  sel;

    // First valid requester at or after rr_ptr, wrapping.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_valid[(int'(rr_ptr_q) + i) % NUM_REQ]) begin
                found = 1'b1;
                sel   = ID_W'((int'(rr_ptr_q) + i) % NUM_REQ);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == StIdle && found && !rst) begin
            req_ready[sel] = 1'b1;
        end
    end

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        id_d          = id_q;
        rsp_id_d      = rsp_id_q;
        cnt_d         = cnt_q;
        x_d           = x_q;
        rsp_y_d       = rsp_y_q;
        lut_x_valid_d = lut_x_valid_q;
        rsp_valid_d   = rsp_valid_q;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    x_d           = req_x[32'(sel) * 16 +: 16];
                    id_d          = sel;
                    cnt_d         = CNT_W'(LUT_LATENCY);
                    lut_x_valid_d = 1'b1;
                    state_d       = StIssue;
                end
            end
            StIssue: begin
                if (cnt_q == '0) begin
                    rsp_y_d       = lut_y;
                    rsp_id_d      = id_q;
                    rsp_valid_d   = 1'b1;
                    lut_x_valid_d = 1'b0;
                    state_d       = StResp;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rr_ptr_d    = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + ID_W'(1);
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            rr_ptr_q      <= '0;
            id_q          <= '0;
            rsp_id_q      <= '0;
            cnt_q         <= '0;
            x_q           <= '0;
            rsp_y_q       <= '0;
            lut_x_valid_q <= 1'b0;
            rsp_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            id_q          <= id_d;
            rsp_id_q      <= rsp_id_d;
            cnt_q         <= cnt_d;
            x_q           <= x_d;
            rsp_y_q       <= rsp_y_d;
            lut_x_valid_q <= lut_x_valid_d;
            rsp_valid_q   <= rsp_valid_d;
        end
    end

    assign lut_x       = x_q;
    assign lut_x_valid = lut_x_valid_q;
    assign rsp_y       = rsp_y_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_valid   = rsp_valid_q;

endmodule
